// File: rtl/rr_ao_mux_arb.sv
// rr_ao_mux_arb
// Registered N-channel arbitrating mux with round-robin priority.
// A rotating one-hot pointer picks one valid channel per cycle. The one-hot
// grant drives an AND-OR data select into a single output register that has a
// valid/ready handshake. With PACKET=1, the grant stays on one channel until a
// beat with in_last=1 is accepted.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   per-channel beat valid
//   in_data    channel i data at [i*WIDTH +: WIDTH]
//   in_last    per-channel end-of-packet flag
//   in_ready   per-channel accept (one-hot or zero), combinational
//   out_valid  output register holds a beat
//   out_data   registered selected data
//   out_sel    one-hot source channel of the current output beat
//   out_last   registered in_last of the selected channel
//   out_ready  downstream accept
module rr_ao_mux_arb #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NINPUTS = 4,
  parameter int unsigned PACKET  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NINPUTS-1:0]         in_valid,
  input  logic [WIDTH*NINPUTS-1:0]   in_data,
  input  logic [NINPUTS-1:0]         in_last,
  output logic [NINPUTS-1:0]         in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [NINPUTS-1:0]         out_sel,
  output logic                       out_last,
  input  logic                       out_ready
);

  logic [NINPUTS-1:0]   ptr;
  logic                 lock;
  logic [NINPUTS-1:0]   locked_grant;

  logic                 load;
  logic [NINPUTS-1:0]   eligible;
  logic [2*NINPUTS-1:0] dbl_req;
  logic [2*NINPUTS-1:0] dbl_gnt;
  logic [NINPUTS-1:0]   grant;
  logic [WIDTH-1:0]     sel_data;
  logic                 sel_last;
  logic                 accept;
  logic [NINPUTS-1:0]   ptr_next;

  assign load     = ~out_valid | out_ready;
  assign eligible = lock ? (in_valid & locked_grant) : in_valid;

  // Round-robin search without an index encoder: on the doubled request
  // vector, subtracting the one-hot pointer borrows up to the first set bit
  // at or above the pointer, so req & ~(req - ptr) isolates that bit.
  // Folding both halves handles the wrap from NINPUTS-1 back to 0.
  assign dbl_req = {eligible, eligible};
  assign dbl_gnt = dbl_req & ~(dbl_req - {{NINPUTS{1'b0}}, ptr});
  assign grant   = dbl_gnt[NINPUTS-1:0] | dbl_gnt[2*NINPUTS-1:NINPUTS];

  assign in_ready = grant & {NINPUTS{load}};
  assign accept   = |in_ready;
  assign ptr_next = {grant[NINPUTS-2:0], grant[NINPUTS-1]};

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NINPUTS; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
    sel_last = |(in_last & grant);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sel      <= '0;
      out_last     <= 1'b0;
      ptr          <= {{(NINPUTS-1){1'b0}}, 1'b1};
      lock         <= 1'b0;
      locked_grant <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= grant;
        out_last  <= sel_last;
        if ((PACKET == 0) || sel_last) begin
          ptr  <= ptr_next;
          lock <= 1'b0;
        end else begin
          lock         <= 1'b1;
          locked_grant <= grant;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_ao_mux_arb.sv
// tb_rr_ao_mux_arb
// Bench for rr_ao_mux_arb: one instance with PACKET=0 and one with PACKET=1,
// both driven by the same stimulus. A fixed vector table covers fairness,
// backpressure, wrap/skip and drain-with-accept. Hand-written sequences cover
// reset and packet locking. A reference arbiter model pushes expected beats
// into per-instance queues on accept; they are popped as the DUT output drains.
module tb_rr_ao_mux_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_valid;
  logic [W*N-1:0] in_data;
  logic [N-1:0]   in_last;
  logic           out_ready;

  logic [N-1:0]   a_rdy, b_rdy;
  logic           a_ov, b_ov;
  logic [W-1:0]   a_od, b_od;
  logic [N-1:0]   a_os, b_os;
  logic           a_ol, b_ol;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_ao_mux_arb #(.WIDTH(W), .NINPUTS(N), .PACKET(0)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(a_rdy), .out_valid(a_ov), .out_data(a_od),
    .out_sel(a_os), .out_last(a_ol), .out_ready(out_ready)
  );

  rr_ao_mux_arb #(.WIDTH(W), .NINPUTS(N), .PACKET(1)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(b_rdy), .out_valid(b_ov), .out_data(b_od),
    .out_sel(b_os), .out_last(b_ol), .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [W-1:0] d;
    logic [N-1:0] s;
    logic         l;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  int    m_ptr [2];
  bit    m_lock[2];
  int    m_own [2];
  bit    m_ov  [2];
  int    waitc [2][N];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d]  = 0;
      m_lock[d] = 0;
      m_own[d]  = 0;
      m_ov[d]   = 0;
      for (int c = 0; c < N; c++) waitc[d][c] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step(input int d, input logic [N-1:0] rdy, input logic ov,
                            input logic [W-1:0] od, input logic [N-1:0] os, input logic ol);
    beat_t   exp_b;
    beat_t   new_b;
    bit      load;
    int      win;
    int      c;
    logic [N-1:0] g;
    chk(d == 0 ? "a_out_valid" : "b_out_valid", {31'd0, ov}, {31'd0, m_ov[d]});
    chk("rdy_onehot0", {31'd0, $onehot0(rdy)}, 32'd1);
    chk("sel_onehot0", {31'd0, $onehot0(os)}, 32'd1);
    if (m_ov[d] && out_ready) begin
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        exp_b = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk(d == 0 ? "a_sb_data" : "b_sb_data", {24'd0, od}, {24'd0, exp_b.d});
        chk(d == 0 ? "a_sb_sel" : "b_sb_sel", {28'd0, os}, {28'd0, exp_b.s});
        chk(d == 0 ? "a_sb_last" : "b_sb_last", {31'd0, ol}, {31'd0, exp_b.l});
      end
    end
    load = !m_ov[d] || out_ready;
    win  = -1;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr[d] + k) % N;
      if (win < 0 && in_valid[c] && (!m_lock[d] || c == m_own[d])) win = c;
    end
    g = '0;
    if (win >= 0 && load) g[win] = 1'b1;
    chk(d == 0 ? "a_model_rdy" : "b_model_rdy", {28'd0, rdy}, {28'd0, g});
    // Starvation bound: in PACKET=0 a continuously valid channel sees at most N-1 other grants.
    if (g != '0) begin
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i]) waitc[d][i] = 0;
        else if (g[i]) waitc[d][i] = 0;
        else begin
          waitc[d][i]++;
          if (d == 0) chk("fair_wait", {31'd0, waitc[d][i] <= N - 1}, 32'd1);
        end
      end
    end
    if (g != '0) begin
      new_b.d = in_data[win*W +: W];
      new_b.s = g;
      new_b.l = in_last[win];
      if (d == 0) q0.push_back(new_b); else q1.push_back(new_b);
      m_ov[d] = 1;
      if (d == 0 || in_last[win]) begin
        m_ptr[d]  = (win + 1) % N;
        m_lock[d] = 0;
      end else begin
        m_lock[d] = 1;
        m_own[d]  = win;
      end
    end else if (out_ready) begin
      m_ov[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      model_reset();
    end else begin
      model_step(0, a_rdy, a_ov, a_od, a_os, a_ol);
      model_step(1, b_rdy, b_ov, b_od, b_os, b_ol);
      chk("a_ptr_onehot", {31'd0, $onehot(u_a.ptr)}, 32'd1);
      chk("b_ptr_onehot", {31'd0, $onehot(u_b.ptr)}, 32'd1);
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [N-1:0] valid;
    logic         ordy;
    logic [N-1:0] exp_rdy;
    logic         exp_ov;
    logic [W-1:0] exp_od;
    logic [N-1:0] exp_os;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic [N-1:0] v, input logic r, input logic [N-1:0] er,
                              input logic eov, input logic [W-1:0] eod, input logic [N-1:0] eos);
    vec_t t;
    t.valid = v; t.ordy = r; t.exp_rdy = er;
    t.exp_ov = eov; t.exp_od = eod; t.exp_os = eos;
    return t;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pkt_drive(input logic [N-1:0] v, input logic [W-1:0] ch1, input logic l1);
    in_valid = v;
    in_data  = {8'h00, 8'h21, ch1, 8'h00};
    in_last  = {1'b0, 1'b1, l1, 1'b0};
  endtask

  initial begin
    // Each row: inputs driven after an edge; in_ready and output registers checked at the following negedge.
    vecs[0]  = mk(4'b1111, 1, 4'b0001, 0, 8'h00, 4'b0000);
    vecs[1]  = mk(4'b1111, 1, 4'b0010, 1, 8'hA0, 4'b0001);
    vecs[2]  = mk(4'b1111, 1, 4'b0100, 1, 8'hA1, 4'b0010);
    vecs[3]  = mk(4'b1111, 1, 4'b1000, 1, 8'hA2, 4'b0100);
    vecs[4]  = mk(4'b1111, 1, 4'b0001, 1, 8'hA3, 4'b1000);
    vecs[5]  = mk(4'b1111, 0, 4'b0000, 1, 8'hA0, 4'b0001);
    vecs[6]  = mk(4'b1111, 0, 4'b0000, 1, 8'hA0, 4'b0001);
    vecs[7]  = mk(4'b1111, 0, 4'b0000, 1, 8'hA0, 4'b0001);
    vecs[8]  = mk(4'b1111, 1, 4'b0010, 1, 8'hA0, 4'b0001);
    vecs[9]  = mk(4'b1111, 1, 4'b0100, 1, 8'hA1, 4'b0010);
    vecs[10] = mk(4'b0011, 1, 4'b0001, 1, 8'hA2, 4'b0100);
    vecs[11] = mk(4'b0011, 1, 4'b0010, 1, 8'hA0, 4'b0001);
    vecs[12] = mk(4'b0000, 1, 4'b0000, 1, 8'hA1, 4'b0010);
    vecs[13] = mk(4'b0000, 1, 4'b0000, 0, 8'hA1, 4'b0010);
    vecs[14] = mk(4'b0100, 1, 4'b0100, 0, 8'hA1, 4'b0010);
    vecs[15] = mk(4'b0100, 1, 4'b0100, 1, 8'hA2, 4'b0100);
    vecs[16] = mk(4'b0000, 1, 4'b0000, 1, 8'hA2, 4'b0100);
    vecs[17] = mk(4'b0000, 0, 4'b0000, 0, 8'hA2, 4'b0100);

    reset     = 1'b0;
    in_valid  = '0;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    in_last   = 4'b1111;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ov", {31'd0, a_ov}, 32'd0);
    chk("rst_a_od", {24'd0, a_od}, 32'd0);
    chk("rst_a_os", {28'd0, a_os}, 32'd0);
    chk("rst_b_ol", {31'd0, b_ol}, 32'd0);
    chk("rst_a_ptr", {28'd0, u_a.ptr}, 32'd1);
    next_cycle();
    reset = 1'b1;

    foreach (vecs[i]) begin
      in_valid  = vecs[i].valid;
      out_ready = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_a_rdy", i), {28'd0, a_rdy}, {28'd0, vecs[i].exp_rdy});
      chk($sformatf("vec%0d_a_ov", i),  {31'd0, a_ov},  {31'd0, vecs[i].exp_ov});
      chk($sformatf("vec%0d_a_od", i),  {24'd0, a_od},  {24'd0, vecs[i].exp_od});
      chk($sformatf("vec%0d_a_os", i),  {28'd0, a_os},  {28'd0, vecs[i].exp_os});
      chk($sformatf("vec%0d_b_rdy", i), {28'd0, b_rdy}, {28'd0, vecs[i].exp_rdy});
      chk($sformatf("vec%0d_b_od", i),  {24'd0, b_od},  {24'd0, vecs[i].exp_od});
      next_cycle();
    end

    // Reset asserted mid-cycle while a beat is held under backpressure.
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    next_cycle();
    chk("pre_rst_a_ov", {31'd0, a_ov}, 32'd1);
    chk("pre_rst_a_od", {24'd0, a_od}, 32'hA3);
    #2;
    reset    = 1'b0;
    in_valid = '0;
    #1;
    chk("async_a_ov", {31'd0, a_ov}, 32'd0);
    chk("async_a_od", {24'd0, a_od}, 32'd0);
    chk("async_a_os", {28'd0, a_os}, 32'd0);
    chk("async_b_ov", {31'd0, b_ov}, 32'd0);
    chk("async_b_od", {24'd0, b_od}, 32'd0);
    chk("async_rdy", {28'd0, a_rdy | b_rdy}, 32'd0);
    next_cycle();
    next_cycle();
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_rdy", {28'd0, a_rdy | b_rdy}, 32'd0);
      chk("idle_ov", {31'd0, a_ov | b_ov}, 32'd0);
      next_cycle();
    end

    // Packet lock: channel 1 sends 11,12,13 with a 2-cycle gap; channel 2 always valid.
    pkt_drive(4'b0110, 8'h11, 1'b0);
    @(negedge clk);
    chk("p0_b_rdy", {28'd0, b_rdy}, 32'b0010);
    chk("p0_a_rdy", {28'd0, a_rdy}, 32'b0010);
    next_cycle();
    pkt_drive(4'b0110, 8'h12, 1'b0);
    @(negedge clk);
    chk("p1_b_rdy", {28'd0, b_rdy}, 32'b0010);
    chk("p1_b_od", {24'd0, b_od}, 32'h11);
    chk("p1_b_ol", {31'd0, b_ol}, 32'd0);
    chk("p1_a_rdy", {28'd0, a_rdy}, 32'b0100);
    next_cycle();
    pkt_drive(4'b0100, 8'h00, 1'b0);
    @(negedge clk);
    chk("p2_b_rdy", {28'd0, b_rdy}, 32'd0);
    chk("p2_b_od", {24'd0, b_od}, 32'h12);
    next_cycle();
    @(negedge clk);
    chk("p3_b_rdy", {28'd0, b_rdy}, 32'd0);
    chk("p3_b_ov", {31'd0, b_ov}, 32'd0);
    next_cycle();
    pkt_drive(4'b0110, 8'h13, 1'b1);
    @(negedge clk);
    chk("p4_b_rdy", {28'd0, b_rdy}, 32'b0010);
    next_cycle();
    pkt_drive(4'b0100, 8'h00, 1'b0);
    @(negedge clk);
    chk("p5_b_rdy", {28'd0, b_rdy}, 32'b0100);
    chk("p5_b_od", {24'd0, b_od}, 32'h13);
    chk("p5_b_ol", {31'd0, b_ol}, 32'd1);
    chk("p5_b_ptr", {28'd0, u_b.ptr}, 32'b0100);
    next_cycle();
    pkt_drive(4'b0000, 8'h00, 1'b0);
    @(negedge clk);
    chk("p6_b_od", {24'd0, b_od}, 32'h21);
    chk("p6_b_os", {28'd0, b_os}, 32'b0100);
    chk("p6_b_ov", {31'd0, b_ov}, 32'd1);
    next_cycle();

    repeat (3) next_cycle();
    @(negedge clk);
    chk("a_sb_empty", q0.size(), 32'd0);
    chk("b_sb_empty", q1.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_ao_mux_arb.md
Name: rr_ao_mux_arb

Overview:
- Registered N-channel arbitrating mux with round-robin priority.
- Each cycle, picks one valid input channel using a rotating one-hot priority pointer, and that one-hot grant drives an AND-OR data select.
- The winning beat is captured in a single output register with a valid/ready handshake.
- Optional packet mode holds the grant on one channel until a multi-beat transfer ends. Used wherever several producers share one downstream consumer, e.g. memory/bus request merging.

Parameters:
- WIDTH, 8, data bits per channel.
- NINPUTS, 4, number of input channels (>=2).
- PACKET, 0, 1 = grant locked until a beat with in_last=1 is accepted; 0 = in_last ignored for arbitration (every beat re-arbitrates).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  NINPUTS  per-channel beat valid.
- in_data  input  WIDTH*NINPUTS  channel i data at bits [i*WIDTH +: WIDTH].
- in_last  input  NINPUTS  per-channel end-of-packet flag.
- in_ready  output  NINPUTS  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  NINPUTS  one-hot source channel of the current output beat.
- out_last  output  1  registered in_last of the selected channel.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (asynchronous, active-low): out_valid=0, out_data=0, out_sel=0, out_last=0, priority pointer=one-hot bit0, lock=0. Reset takes effect immediately, mid-packet or mid-stall. Any partial packet is abandoned; no beat is output after reset release until a new acceptance.
- load = ~out_valid | out_ready. This gives full throughput of one beat per cycle through a draining register.
- Eligible set: in_valid when lock=0; in_valid & locked_grant when lock=1.
- Grant: the first eligible channel at or after the pointer, searching upward with wrap from NINPUTS-1 to 0. The grant is one-hot, or zero if nothing is eligible.
- in_ready = grant & {NINPUTS{load}}. Combinational; depends on in_valid and out_ready in the same cycle.
- Accept (any in_ready bit set) at edge k: at k+1, out_valid=1, out_data=AND-OR select of in_data by grant, out_sel=grant, out_last=selected in_last. Latency is 1 cycle.
- If out_valid & out_ready with no accept: out_valid->0 and data/sel/last hold their old values.
- If out_valid & ~out_ready: all in_ready=0 and the output register holds.
- Pointer update, on accept only:
  - PACKET=0, or the accepted beat has in_last=1: pointer = grant rotated left by 1 (the channel after the winner, wrapping NINPUTS-1 -> 0), lock=0.
  - PACKET=1 and the accepted beat has in_last=0: lock=1, locked_grant=grant, pointer unchanged.
- Locked with the owner's in_valid=0: no grant. Other channels stall (no interleaving) until the owner resumes.
- No accept: pointer, lock and locked_grant unchanged. The pointer never rotates on idle cycles.
- A single-beat packet (in_last=1 on the first beat) in PACKET=1 behaves exactly as in PACKET=0.
- Invariants (bench assertions): in_ready and out_sel are one-hot or zero; the pointer is always exactly one-hot; no channel waits more than NINPUTS-1 grants while continuously valid when PACKET=0.

Test Plan:
- Reset then idle. Hold reset low mid-stream with out_valid=1 -> all outputs 0 immediately. After release with in_valid=0 for 5 cycles: in_ready=0 and out_valid=0 throughout.
- Fairness, NINPUTS=4, WIDTH=8, PACKET=0. in_valid=4'b1111, channel i data = 8'hA0+i, out_ready=1 -> out_data sequence A0,A1,A2,A3,A0,… with out_sel 0001,0010,0100,1000, one beat per cycle after 1-cycle latency.
- Backpressure. Same traffic with out_ready=0 for 3 cycles after the first beat -> out_valid=1, out_data=A0 held, in_ready=0. On out_ready=1 -> the next beat is A1 with no loss or duplication.
- Wrap and skip. Pointer at channel 3 (after granting channel 2) with in_valid=4'b0011 -> grant channel 0 (data A0), then pointer=channel 1.
- Packet lock, PACKET=1. Channel 1 sends 3 beats (11,12,13; last on 13) while channel 2 is continuously valid; channel 1 in_valid drops for 2 cycles between beats 12 and 13 -> channel 2 in_ready=0 throughout. Output is 11,12,13, then channel 2's beat. The pointer is then channel 2.
- Simultaneous drain and accept. out_valid=1, out_ready=1, in_valid=4'b0100 -> in_ready=4'b0100 in the same cycle. Next cycle: out_valid stays 1 with the channel-2 data and out_sel=4'b0100.
